bcd_seq_conv: RTL and testbench
===============================

Name: bcd_seq_conv

Overview:
- Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble), one bit per clock.
- Sits between the arithmetic/counter logic and the 4-digit seg_driver. Its bcd_out drives seg_driver data_in directly.
- Adds a start/done handshake and a leading-zero blanking mask, so wide binary values are converted without a large combinational cone.

Parameters:
- BIN_W, 9, width of binary input. Legal range 4..16.
- DIGITS, 5, number of BCD digits in output; output width is 4*DIGITS (20 at default).
- Legality rule: 10^DIGITS must exceed 2^BIN_W-1. An illegal combination is a synthesis-time error (generate-time check), not runtime behaviour.

Ports:
- sys_clk    in   1          system clock, all logic on rising edge
- sys_rst    in   1          synchronous reset, active-high
- start      in   1          request conversion of bin_in; sampled each cycle
- bin_in     in   BIN_W      unsigned binary value; sampled only on an accepted start
- busy       out  1          high while conversion in progress
- done       out  1          one-cycle pulse; bcd_out/blank valid and updated this cycle
- bcd_out    out  4*DIGITS   packed BCD, digit 0 = bits [3:0] (ones); held until next done
- blank      out  DIGITS     1 = leading zero digit to be blanked; bit 0 always 0

Behaviour:
- Reset (sys_rst=1 at a clock edge), regardless of state:
  - state=IDLE, busy=0, done=0, bcd_out=0, blank={DIGITS-1{1'b1},1'b0}.
  - The internal shift register and bit counter are cleared.
- FSM states and transitions:
  - IDLE: start=1 -> load shift reg with bin_in in the low bits and zeros in the BCD field; bit counter=BIN_W; go to SHIFT.
  - SHIFT: busy=1. Each cycle, first add 3 to every BCD nibble >=5 (all nibbles in parallel), then shift the whole register left by 1 and decrement the counter. When the counter reaches 1 at this cycle's shift, go to DONE and register the final BCD field into bcd_out.
  - DONE: done=1, busy=0 for exactly one cycle. start=1 -> accepted as in IDLE (back-to-back; next state SHIFT); else go to IDLE.
- Latency:
  - start accepted at cycle 0.
  - SHIFT occupies cycles 1..BIN_W.
  - done=1 at cycle BIN_W+1 (10 at default).
  - Throughput is one result per BIN_W+1 cycles.
- start while in SHIFT is ignored entirely; no queuing and no effect on the in-flight value.
- bin_in changes during SHIFT have no effect.
- bcd_out and blank change only in the cycle done is asserted (or at reset); seg_driver may read them continuously.
- Blank mask:
  - blank[i]=1 iff digit i and all higher digits are zero, for i>=1.
  - blank[0]=0 always, so value 0 displays a single "0".
  - Computed from the new BCD value and registered with bcd_out.
- Arithmetic:
  - The add-3 is 4-bit per nibble; no carry crosses nibble boundaries.
  - The BCD field is exactly 4*DIGITS bits.
  - Legal parameters guarantee no overflow out of the top nibble.
- Reset mid-conversion aborts: no done pulse; outputs return to reset values.

Test Plan:
- Reset, then start=1 for one cycle with bin_in=9'd255 at cycle 0 -> busy=1 in cycles 1..9; done=1 only in cycle 10; bcd_out=20'h00255, blank=5'b11000.
- Boundary values, one conversion each:
  - bin_in=0 -> bcd_out=20'h00000, blank=5'b11110.
  - bin_in=511 -> bcd_out=20'h00511, blank=5'b11000.
  - bin_in=10 -> bcd_out=20'h00010, blank=5'b11100.
- Start ignored while busy: start with 9'd100 at cycle 0, start with 9'd7 at cycle 4 -> single done at cycle 10 with bcd_out=20'h00100; no second done through cycle 30.
- Back-to-back: start with 9'd42 at cycle 0, start held high through cycle 10 with bin_in=9'd300 at cycle 10 -> done at 10 (20'h00042), busy cycles 11..19, done at 20 (20'h00300). bcd_out stays 20'h00042 during cycles 11..19.
- Reset mid-operation: start with 9'd123 at cycle 0, sys_rst=1 at cycle 5 -> from cycle 6 busy=0, bcd_out=0, blank=5'b11110; no done pulse follows.
- Randomised sweep of all 512 input values, compared against a reference model; done count equals accepted-start count.

Source files
------------

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a
// start/done handshake and a registered leading-zero blanking mask.
module bcd_seq_conv #(
    parameter int BIN_W  = 9,
    parameter int DIGITS = 5
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] MAX_BIN   = (64'd1 << BIN_W) - 64'd1;
    localparam bit          PARAMS_OK = (BIN_W >= 4) && (BIN_W <= 16) && (DIGITS >= 1)
                                        && (pow10(DIGITS) > MAX_BIN);

    // The BCD field must hold the largest input, otherwise the top nibble overflows.
    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("bcd_seq_conv: illegal BIN_W/DIGITS combination");
        end
    endgenerate

    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [SR_W-1:0]    sr_reg;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_shift;
    logic [CNT_W-1:0]   cnt_reg;
    logic [BCD_W-1:0]   bcd_new;
    logic [DIGITS-1:0]  blank_new;
    logic               accept;
    logic               last_shift;

    // Add-3 correction, each nibble independent (no inter-nibble carry).
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            localparam int LSB = BIN_W + 4 * gi;
            assign sr_adj[LSB +: 4] = (sr_reg[LSB +: 4] >= 4'd5) ? (sr_reg[LSB +: 4] + 4'd3)
                                                                 : sr_reg[LSB +: 4];
        end
    endgenerate
    assign sr_adj[BIN_W-1:0] = sr_reg[BIN_W-1:0];

    assign sr_shift = sr_adj << 1;
    assign bcd_new  = sr_shift[SR_W-1 -: BCD_W];

    assign blank_new[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign blank_new[gi] = (bcd_new[BCD_W-1:4*gi] == '0);
        end
    endgenerate

    assign accept     = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign last_shift = (state_reg == S_SHIFT) && (cnt_reg == CNT_W'(1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_SHIFT;
            S_SHIFT: if (cnt_reg == CNT_W'(1)) state_next = S_DONE;
            S_DONE:  state_next = start ? S_SHIFT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == S_SHIFT);
        done = (state_reg == S_DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sr_reg  <= '0;
            cnt_reg <= '0;
            bcd_out <= '0;
            blank   <= BLANK_RST;
        end else begin
            if (accept) begin
                sr_reg  <= {{BCD_W{1'b0}}, bin_in};
                cnt_reg <= CNT_W'(BIN_W);
            end else if (state_reg == S_SHIFT) begin
                sr_reg  <= sr_shift;
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            // Outputs update only with the final shift, so they stay stable between results.
            if (last_shift) begin
                bcd_out <= bcd_new;
                blank   <= blank_new;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Self-checking bench for bcd_seq_conv: directed timing scenarios plus a shuffled
// sweep of every input value against a decimal-arithmetic reference model.
module tb_bcd_seq_conv;

    localparam int BIN_W  = 9;
    localparam int DIGITS = 5;
    localparam int BCD_W  = 4 * DIGITS;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               start;
    logic [BIN_W-1:0]   bin_in;
    logic               busy;
    logic               done;
    logic [BCD_W-1:0]   bcd_out;
    logic [DIGITS-1:0]  blank;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sys_clk = ~sys_clk;

    bcd_seq_conv #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .blank   (blank)
    );

    function automatic logic [BCD_W-1:0] model_bcd(input int v);
        logic [BCD_W-1:0] r;
        int rem;
        r   = '0;
        rem = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] model_blank(input int v);
        logic [DIGITS-1:0] b;
        int p;
        b = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    task automatic test_reset();
        sys_rst = 1'b1;
        start   = 1'b0;
        bin_in  = '0;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got=%b want=00", {busy, done});
        else n_pass++;
        n_checks++;
        if (bcd_out !== 20'h00000) $display("FAIL reset_bcd got=%h want=00000", bcd_out);
        else n_pass++;
        n_checks++;
        if (blank !== 5'b11110) $display("FAIL reset_blank got=%b want=11110", blank);
        else n_pass++;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset got=%b want=00", {busy, done});
        else n_pass++;
    endtask

    task automatic test_latency();
        start  = 1'b1;
        bin_in = 9'd255;
        for (int c = 1; c <= 12; c++) begin
            @(negedge sys_clk);
            if (c == 1) start = 1'b0;
            n_checks++;
            if ({busy, done} !== {(c >= 1 && c <= 9), (c == 10)})
                $display("FAIL latency_busy_done cycle=%0d got=%b want=%b", c, {busy, done},
                         {(c >= 1 && c <= 9), (c == 10)});
            else n_pass++;
            if (c < 10) begin
                n_checks++;
                if (bcd_out !== 20'h00000) $display("FAIL latency_hold cycle=%0d got=%h want=00000", c, bcd_out);
                else n_pass++;
            end
            if (c == 10) begin
                n_checks++;
                if (bcd_out !== 20'h00255) $display("FAIL latency_bcd got=%h want=00255", bcd_out);
                else n_pass++;
                n_checks++;
                if (blank !== 5'b11000) $display("FAIL latency_blank got=%b want=11000", blank);
                else n_pass++;
            end
        end
    endtask

    task automatic test_boundary();
        int                vals[3]      = '{0, 511, 10};
        logic [BCD_W-1:0]  exp_bcd[3]   = '{20'h00000, 20'h00511, 20'h00010};
        logic [DIGITS-1:0] exp_blank[3] = '{5'b11110, 5'b11000, 5'b11100};
        for (int k = 0; k < 3; k++) begin
            start  = 1'b1;
            bin_in = BIN_W'(vals[k]);
            for (int c = 1; c <= 11; c++) begin
                @(negedge sys_clk);
                if (c == 1) start = 1'b0;
                n_checks++;
                if (done !== (c == 10)) $display("FAIL boundary_done val=%0d cycle=%0d got=%b", vals[k], c, done);
                else n_pass++;
                if (c == 10) begin
                    n_checks++;
                    if (bcd_out !== exp_bcd[k])
                        $display("FAIL boundary_bcd val=%0d got=%h want=%h", vals[k], bcd_out, exp_bcd[k]);
                    else n_pass++;
                    n_checks++;
                    if (blank !== exp_blank[k])
                        $display("FAIL boundary_blank val=%0d got=%b want=%b", vals[k], blank, exp_blank[k]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        start  = 1'b1;
        bin_in = 9'd100;
        for (int c = 1; c <= 30; c++) begin
            @(negedge sys_clk);
            n_checks++;
            if (done !== (c == 10)) $display("FAIL ignore_done cycle=%0d got=%b want=%b", c, done, (c == 10));
            else n_pass++;
            if (c == 10 || c == 30) begin
                n_checks++;
                if (bcd_out !== 20'h00100) $display("FAIL ignore_bcd cycle=%0d got=%h want=00100", c, bcd_out);
                else n_pass++;
            end
            start = (c == 4);
            if (c == 4) bin_in = 9'd7;
            if (c == 6) bin_in = BIN_W'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        start  = 1'b1;
        bin_in = 9'd42;
        for (int c = 1; c <= 21; c++) begin
            @(negedge sys_clk);
            n_checks++;
            if ({busy, done} !== {(c != 10 && c != 20 && c != 21), (c == 10 || c == 20)})
                $display("FAIL b2b_busy_done cycle=%0d got=%b want=%b", c, {busy, done},
                         {(c != 10 && c != 20 && c != 21), (c == 10 || c == 20)});
            else n_pass++;
            if (c >= 10 && c <= 19) begin
                n_checks++;
                if (bcd_out !== 20'h00042) $display("FAIL b2b_first_bcd cycle=%0d got=%h want=00042", c, bcd_out);
                else n_pass++;
            end
            if (c == 20) begin
                n_checks++;
                if (bcd_out !== 20'h00300) $display("FAIL b2b_second_bcd got=%h want=00300", bcd_out);
                else n_pass++;
            end
            if (c == 10) bin_in = 9'd300;
            if (c == 11) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        start  = 1'b1;
        bin_in = 9'd123;
        for (int c = 1; c <= 20; c++) begin
            @(negedge sys_clk);
            if (c == 1) start = 1'b0;
            if (c >= 6) begin
                n_checks++;
                if ({busy, done} !== 2'b00) $display("FAIL rstmid_busy_done cycle=%0d got=%b want=00", c, {busy, done});
                else n_pass++;
            end
            if (c == 6 || c == 20) begin
                n_checks++;
                if (bcd_out !== 20'h00000) $display("FAIL rstmid_bcd cycle=%0d got=%h want=00000", c, bcd_out);
                else n_pass++;
                n_checks++;
                if (blank !== 5'b11110) $display("FAIL rstmid_blank cycle=%0d got=%b want=11110", c, blank);
                else n_pass++;
            end
            sys_rst = (c == 5);
        end
    endtask

    task automatic test_sweep();
        int perm[512];
        int tmp, j, cyc, dones, cur;
        bit got;
        for (int i = 0; i < 512; i++) perm[i] = i;
        for (int i = 511; i > 0; i--) begin
            j       = int'($urandom_range(i, 0));
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        dones  = 0;
        cur    = perm[0];
        start  = 1'b1;
        bin_in = BIN_W'(cur);
        for (int n = 0; n < 512; n++) begin
            cyc = 0;
            got = 1'b0;
            while (!got && cyc < 20) begin
                @(negedge sys_clk);
                cyc++;
                if (done) begin
                    got = 1'b1;
                end else begin
                    start  = 1'($urandom);
                    bin_in = BIN_W'($urandom);
                end
            end
            if (got) dones++;
            n_checks++;
            if (!got || cyc != BIN_W + 1)
                $display("FAIL sweep_latency val=%0d got_done=%0d cycles=%0d want=%0d", cur, got, cyc, BIN_W + 1);
            else n_pass++;
            n_checks++;
            if (bcd_out !== model_bcd(cur))
                $display("FAIL sweep_bcd val=%0d got=%h want=%h", cur, bcd_out, model_bcd(cur));
            else n_pass++;
            n_checks++;
            if (blank !== model_blank(cur))
                $display("FAIL sweep_blank val=%0d got=%b want=%b", cur, blank, model_blank(cur));
            else n_pass++;
            if (n < 511) begin
                cur = perm[n + 1];
                if (($urandom & 1) == 0) begin
                    start = 1'b0;
                    @(negedge sys_clk);
                    n_checks++;
                    if ({busy, done} !== 2'b00) $display("FAIL sweep_idle val=%0d got=%b want=00", cur, {busy, done});
                    else n_pass++;
                end
                start  = 1'b1;
                bin_in = BIN_W'(cur);
            end else begin
                start = 1'b0;
            end
        end
        repeat (25) begin
            @(negedge sys_clk);
            if (done) dones++;
        end
        n_checks++;
        if (dones != 512) $display("FAIL sweep_done_count got=%0d want=512", dones);
        else n_pass++;
    endtask

    initial begin
        sys_rst = 1'b1;
        start   = 1'b0;
        bin_in  = '0;
        test_reset();
        test_latency();
        test_boundary();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
